// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared defaults and mode encoding for the 8-channel demultiplexer
package demux_pkg;

    localparam int DEMUX_N_CH  = 8;
    localparam int DEMUX_SEL_W = $clog2(DEMUX_N_CH);

    typedef enum logic {
        MODE_ADDR = 1'b0,
        MODE_RR   = 1'b1
    } mode_e;

endpackage

// File: rtl/demux_ptr_cnt.sv
// rtl/demux_ptr_cnt.sv - round-robin pointer, frame wrap and auto_en edge detection
module demux_ptr_cnt
    import demux_pkg::*;
#(
    parameter int N_CH  = DEMUX_N_CH,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic             i_auto_en,
    output logic [SEL_W-1:0] o_ptr,
    output logic [SEL_W-1:0] o_wr_ptr,
    output logic             o_wrap
);

    logic [SEL_W-1:0] r_ptr;
    logic             r_auto_prev;
    logic             w_rise;
    logic             w_fall;
    logic             w_adv;
    logic [SEL_W-1:0] w_wr_ptr;

    // Entering round-robin restarts the frame at channel 0 in the same cycle,
    // so a bit arriving with the rising edge of auto_en lands on channel 0.
    assign w_rise   = i_auto_en & ~r_auto_prev;
    assign w_fall   = ~i_auto_en & r_auto_prev;
    assign w_wr_ptr = w_rise ? '0 : r_ptr;
    assign w_adv    = i_valid & i_auto_en & ~i_clear;

    assign o_ptr    = r_ptr;
    assign o_wr_ptr = w_wr_ptr;
    assign o_wrap   = w_adv & (w_wr_ptr == SEL_W'(N_CH - 1));

    // Pointer advances on accepted round-robin bits; leaving round-robin or
    // clearing abandons the partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_auto_prev <= 1'b0;
        end else begin
            r_auto_prev <= i_auto_en;
            if (i_clear || w_fall) begin
                r_ptr <= '0;
            end else if (w_adv) begin
                r_ptr <= w_wr_ptr + SEL_W'(1);
            end else if (w_rise) begin
                r_ptr <= '0;
            end
        end
    end

endmodule

// File: rtl/demux_8ch.sv
// rtl/demux_8ch.sv - serial bit demultiplexer with addressed and round-robin modes
module demux_8ch
    import demux_pkg::*;
#(
    parameter int N_CH  = DEMUX_N_CH,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_data,
    input  logic [SEL_W-1:0] sel,
    input  logic             auto_en,
    input  logic             clear,
    output logic [N_CH-1:0]  out_q,
    output logic [N_CH-1:0]  out_strobe,
    output logic             frame_done,
    output logic [SEL_W-1:0] ptr
);

    mode_e            w_mode;
    logic [SEL_W-1:0] w_rr_idx;
    logic [SEL_W-1:0] w_idx;
    logic             w_wrap;
    logic             w_accept;
    logic [N_CH-1:0]  w_onehot;
    logic [N_CH-1:0]  r_q;
    logic [N_CH-1:0]  r_strobe;
    logic             r_frame_done;

    demux_ptr_cnt #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_ptr_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (clear),
        .i_valid   (in_valid),
        .i_auto_en (auto_en),
        .o_ptr     (ptr),
        .o_wr_ptr  (w_rr_idx),
        .o_wrap    (w_wrap)
    );

    assign w_mode   = auto_en ? MODE_RR : MODE_ADDR;
    assign w_idx    = (w_mode == MODE_RR) ? w_rr_idx : sel;
    assign w_accept = in_valid & ~clear;
    assign w_onehot = N_CH'(1) << w_idx;

    // Capture the routed bit and flag the written channel for one cycle;
    // clear wins over a valid bit in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q          <= '0;
            r_strobe     <= '0;
            r_frame_done <= 1'b0;
        end else if (clear) begin
            r_q          <= '0;
            r_strobe     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_strobe     <= w_accept ? w_onehot : '0;
            r_frame_done <= w_wrap;
            if (w_accept) begin
                r_q[w_idx] <= in_data;
            end
        end
    end

    assign out_q      = r_q;
    assign out_strobe = r_strobe;
    assign frame_done = r_frame_done;

endmodule
